// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding select,
// load-use stalls (load latency 1 or 2), memory-busy freeze, branch flush and event counters.
module hazard_ctrl_unit #(
    parameter int AW       = 5,
    parameter int NUM_SRC  = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC*AW-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]     id_src_valid,
    input  logic                   ex_rf_en,
    input  logic                   mem_rf_en,
    input  logic                   wb_rf_en,
    input  logic [AW-1:0]          ex_dst,
    input  logic [AW-1:0]          mem_dst,
    input  logic [AW-1:0]          wb_dst,
    input  logic                   ex_is_load,
    input  logic                   mem_is_load,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   pc_le,
    output logic                   ifid_le,
    output logic                   pipe_le,
    output logic                   ctrl_bubble,
    output logic                   ifid_flush,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       freeze_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LSTALL = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   freeze_cnt_q, freeze_cnt_d;
    logic [NUM_SRC-1:0] m_ex_s, m_mem_s, m_wb_s;
    logic [1:0]         need_s;
    logic               stall_s, flush_s, freeze_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Per-operand match against each producing stage; address 0 is excluded when hardwired.
    always_comb begin
        m_ex_s  = '0;
        m_mem_s = '0;
        m_wb_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [AW-1:0] a;
            logic          live;
            a    = id_src_addr[i*AW +: AW];
            live = id_src_valid[i] & !((ZERO_REG != 0) && (a == '0));
            m_ex_s[i]  = live & ex_rf_en  & (a == ex_dst);
            m_mem_s[i] = live & mem_rf_en & (a == mem_dst);
            m_wb_s[i]  = live & wb_rf_en  & (a == wb_dst);
        end
    end

    // Forwarding select: the youngest matching stage wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_ex_s[i]) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end else if (m_mem_s[i]) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (m_wb_s[i]) begin
                fwd_sel[2*i +: 2] = 2'b11;
            end else begin
                fwd_sel[2*i +: 2] = 2'b00;
            end
        end
    end

    // Bubble count required by a load-use dependency seen from IDLE.
    always_comb begin
        if ((|m_ex_s) && ex_is_load) begin
            need_s = 2'(LOAD_LAT);
        end else if ((LOAD_LAT == 2) && (|m_mem_s) && mem_is_load) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Priority arbitration freeze > flush > stall; freeze holds the FSM untouched.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        freeze_s = 1'b0;
        if (mem_busy) begin
            freeze_s = 1'b1;
        end else if (ex_branch_taken) begin
            flush_s = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else if (state_q == ST_LSTALL) begin
            stall_s = 1'b1;
            cnt_d   = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_LSTALL;
            end
        end else if (need_s != 2'd0) begin
            stall_s = 1'b1;
            if (need_s == 2'd2) begin
                state_d = ST_LSTALL;
                cnt_d   = 2'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Pipeline enables derived from the mutually exclusive freeze/flush/stall conditions.
    always_comb begin
        pc_le       = !(freeze_s | stall_s);
        ifid_le     = !(freeze_s | stall_s);
        pipe_le     = !freeze_s;
        ctrl_bubble = stall_s | flush_s;
        ifid_flush  = flush_s;
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d  = stall_s  ? sat_inc(stall_cnt_q)  : stall_cnt_q;
        flush_cnt_d  = flush_s  ? sat_inc(flush_cnt_q)  : flush_cnt_q;
        freeze_cnt_d = freeze_s ? sat_inc(freeze_cnt_q) : freeze_cnt_q;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (latency 1, latency 2, latency 2 with 2-bit
// counters) share stimulus and are checked against a remaining-bubbles reference model.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] id_src_addr = '0;
    logic [2:0]  id_src_valid = '0;
    logic        ex_rf_en = 1'b0, mem_rf_en = 1'b0, wb_rf_en = 1'b0;
    logic [4:0]  ex_dst = '0, mem_dst = '0, wb_dst = '0;
    logic        ex_is_load = 1'b0, mem_is_load = 1'b0;
    logic        ex_branch_taken = 1'b0, mem_busy = 1'b0;

    logic [5:0]  fwd0, fwd1, fwd2;
    logic        pc0, pc1, pc2, ifid0, ifid1, ifid2, pipe0, pipe1, pipe2;
    logic        bub0, bub1, bub2, fl0, fl1, fl2;
    logic [15:0] sc0, sc1, fc0, fc1, zc0, zc1;
    logic [1:0]  sc2, fc2, zc2;

    int total = 0;
    int bad = 0;

    int rem[3];
    int msc[3];
    int mfc[3];
    int mzc[3];
    int lat[3] = '{1, 2, 2};
    int cw[3]  = '{16, 16, 2};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.AW(5), .NUM_SRC(3), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .fwd_sel(fwd0), .pc_le(pc0), .ifid_le(ifid0), .pipe_le(pipe0), .ctrl_bubble(bub0),
        .ifid_flush(fl0), .stall_cnt(sc0), .flush_cnt(fc0), .freeze_cnt(zc0));

    hazard_ctrl_unit #(.AW(5), .NUM_SRC(3), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .fwd_sel(fwd1), .pc_le(pc1), .ifid_le(ifid1), .pipe_le(pipe1), .ctrl_bubble(bub1),
        .ifid_flush(fl1), .stall_cnt(sc1), .flush_cnt(fc1), .freeze_cnt(zc1));

    hazard_ctrl_unit #(.AW(5), .NUM_SRC(3), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .fwd_sel(fwd2), .pc_le(pc2), .ifid_le(ifid2), .pipe_le(pipe2), .ctrl_bubble(bub2),
        .ifid_flush(fl2), .stall_cnt(sc2), .flush_cnt(fc2), .freeze_cnt(zc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit match(input int i, input logic en, input logic [4:0] dst);
        logic [4:0] a;
        a = id_src_addr[i*5 +: 5];
        return id_src_valid[i] && en && (a == dst) && (a != 5'd0);
    endfunction

    function automatic int need_of(input int l);
        bit any_ex = 0;
        bit any_mem = 0;
        for (int i = 0; i < 3; i++) begin
            if (match(i, ex_rf_en, ex_dst)) any_ex = 1;
            if (match(i, mem_rf_en, mem_dst)) any_mem = 1;
        end
        if (any_ex && ex_is_load) return l;
        if (l == 2 && any_mem && mem_is_load) return 1;
        return 0;
    endfunction

    function automatic logic [5:0] fwd_model();
        logic [5:0] s = '0;
        for (int i = 0; i < 3; i++) begin
            if (match(i, ex_rf_en, ex_dst)) s[2*i +: 2] = 2'd1;
            else if (match(i, mem_rf_en, mem_dst)) s[2*i +: 2] = 2'd2;
            else if (match(i, wb_rf_en, wb_dst)) s[2*i +: 2] = 2'd3;
        end
        return s;
    endfunction

    function automatic int sat(input int v, input int w);
        return (v >= (1 << w) - 1) ? (1 << w) - 1 : v + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; msc[k] = 0; mfc[k] = 0; mzc[k] = 0;
        end
    endtask

    // One clock of the reference model: outstanding bubbles drain unless frozen or flushed.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = need_of(lat[k]);
            if (mem_busy) begin
                mzc[k] = sat(mzc[k], cw[k]);
            end else if (ex_branch_taken) begin
                rem[k] = 0;
                mfc[k] = sat(mfc[k], cw[k]);
            end else if (rem[k] > 0) begin
                rem[k]--;
                msc[k] = sat(msc[k], cw[k]);
            end else if (n > 0) begin
                rem[k] = n - 1;
                msc[k] = sat(msc[k], cw[k]);
            end
        end
    endtask

    task automatic check_all();
        logic [5:0]  f_o;
        logic        p_o, i_o, pl_o, b_o, fl_o;
        logic [15:0] s_o, c_o, z_o;
        bit          st, fl;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin f_o = fwd0; p_o = pc0; i_o = ifid0; pl_o = pipe0; b_o = bub0; fl_o = fl0;
                         s_o = sc0; c_o = fc0; z_o = zc0; end
                1: begin f_o = fwd1; p_o = pc1; i_o = ifid1; pl_o = pipe1; b_o = bub1; fl_o = fl1;
                         s_o = sc1; c_o = fc1; z_o = zc1; end
                default: begin f_o = fwd2; p_o = pc2; i_o = ifid2; pl_o = pipe2; b_o = bub2; fl_o = fl2;
                         s_o = {14'd0, sc2}; c_o = {14'd0, fc2}; z_o = {14'd0, zc2}; end
            endcase
            st = !mem_busy && !ex_branch_taken && (rem[k] > 0 || need_of(lat[k]) > 0);
            fl = !mem_busy && ex_branch_taken;
            chk($sformatf("u%0d_fwd", k), 32'(f_o), 32'(fwd_model()));
            chk($sformatf("u%0d_pc_le", k), 32'(p_o), 32'(!mem_busy && !st));
            chk($sformatf("u%0d_ifid_le", k), 32'(i_o), 32'(!mem_busy && !st));
            chk($sformatf("u%0d_pipe_le", k), 32'(pl_o), 32'(!mem_busy));
            chk($sformatf("u%0d_bubble", k), 32'(b_o), 32'(st || fl));
            chk($sformatf("u%0d_flush", k), 32'(fl_o), 32'(fl));
            chk($sformatf("u%0d_stall_cnt", k), 32'(s_o), 32'(msc[k]));
            chk($sformatf("u%0d_flush_cnt", k), 32'(c_o), 32'(mfc[k]));
            chk($sformatf("u%0d_freeze_cnt", k), 32'(z_o), 32'(mzc[k]));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        id_src_addr = '0; id_src_valid = '0;
        ex_rf_en = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
        ex_dst = '0; mem_dst = '0; wb_dst = '0;
        ex_is_load = 1'b0; mem_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        #1 rst_n = 1'b1;
    endtask

    task automatic load_use_in_ex();
        clear_inputs();
        ex_rf_en = 1'b1; ex_dst = 5'd5; ex_is_load = 1'b1;
        id_src_addr[9:5] = 5'd5; id_src_valid = 3'b010;
    endtask

    task automatic load_in_mem();
        ex_rf_en = 1'b0; ex_is_load = 1'b0;
        mem_rf_en = 1'b1; mem_dst = 5'd5; mem_is_load = 1'b1;
    endtask

    task automatic load_in_wb();
        mem_rf_en = 1'b0; mem_is_load = 1'b0;
        wb_rf_en = 1'b1; wb_dst = 5'd5;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        #2 check_all();
        chk("rst_stall_cnt", 32'(sc0), 32'd0);
        do_reset();

        // Forwarding priority with ZERO_REG
        id_src_addr[4:0] = 5'd3; id_src_valid = 3'b001;
        ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
        ex_dst = 5'd3; mem_dst = 5'd3; wb_dst = 5'd3;
        #1 chk("fwd_ex_wins", 32'(fwd0[1:0]), 32'd1);
        cycle();
        ex_rf_en = 1'b0;
        #1 chk("fwd_mem_next", 32'(fwd0[1:0]), 32'd2);
        cycle();
        id_src_addr[4:0] = 5'd0; ex_rf_en = 1'b1; ex_dst = 5'd0; mem_dst = 5'd0; wb_dst = 5'd0;
        #1 chk("fwd_zero_reg", 32'(fwd0[1:0]), 32'd0);
        cycle();

        // Load-use: latency 1 (u1) and adjacent latency 2 (u2)
        do_reset();
        load_use_in_ex();
        #1 chk("l1_pc_le", 32'(pc0), 32'd0);
        chk("l1_ifid_le", 32'(ifid0), 32'd0);
        chk("l1_bubble", 32'(bub0), 32'd1);
        cycle();
        load_in_mem();
        #1 chk("l1_fwd_mem", 32'(fwd0[3:2]), 32'd2);
        chk("l1_released", 32'(pc0), 32'd1);
        chk("l2_second_stall", 32'(pc1), 32'd0);
        chk("l1_stall_cnt", 32'(sc0), 32'd1);
        cycle();
        load_in_wb();
        #1 chk("l2_fwd_wb", 32'(fwd1[3:2]), 32'd3);
        chk("l2_released", 32'(pc1), 32'd1);
        chk("l2_stall_cnt", 32'(sc1), 32'd2);
        cycle();

        // Freeze for 3 cycles while u2 is in its second stall cycle
        do_reset();
        load_use_in_ex();
        cycle();
        load_in_mem();
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("frz_pipe_le", 32'(pipe1), 32'd0);
            cycle();
        end
        mem_busy = 1'b0;
        #1 chk("frz_remaining_stall", 32'(pc1), 32'd0);
        cycle();
        load_in_wb();
        #1 chk("frz_released", 32'(pc1), 32'd1);
        chk("frz_freeze_cnt", 32'(zc1), 32'd3);
        chk("frz_stall_cnt", 32'(sc1), 32'd2);
        cycle();

        // Flush while u2 is in its second stall cycle
        do_reset();
        load_use_in_ex();
        cycle();
        load_in_mem();
        ex_branch_taken = 1'b1;
        #1 chk("fl_ifid_flush", 32'(fl1), 32'd1);
        chk("fl_pc_le", 32'(pc1), 32'd1);
        cycle();
        clear_inputs();
        #1 chk("fl_idle_after", 32'(pc1), 32'd1);
        chk("fl_flush_cnt", 32'(fc1), 32'd1);
        chk("fl_stall_cnt", 32'(sc1), 32'd1);
        cycle();

        // Saturation of a 2-bit counter, then asynchronous reset mid-stall
        do_reset();
        load_use_in_ex();
        for (int c = 0; c < 5; c++) cycle();
        clear_inputs();
        #1 chk("sat_stall_cnt", 32'(sc2), 32'd3);
        chk("sat_in_lstall", 32'(pc2), 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1 chk("arst_stall_gone", 32'(pc2), 32'd1);
        chk("arst_stall_cnt", 32'(sc2), 32'd0);
        chk("arst_u2_stall_cnt", 32'(sc1), 32'd0);
        check_all();
        rst_n = 1'b1;
        cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) id_src_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
            id_src_valid    = 3'($urandom_range(0, 7));
            ex_rf_en        = 1'($urandom_range(0, 1));
            mem_rf_en       = 1'($urandom_range(0, 1));
            wb_rf_en        = 1'($urandom_range(0, 1));
            ex_dst          = 5'($urandom_range(0, 3));
            mem_dst         = 5'($urandom_range(0, 3));
            wb_dst          = 5'($urandom_range(0, 3));
            ex_is_load      = 1'($urandom_range(0, 1));
            mem_is_load     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
